// File: rtl/vx_dispatch_arbiter_pkg.sv
// Shared GPU definitions used by the dispatch arbiter: counter width,
// slice-index width helper and the dispatch payload layout.
package VX_gpu_pkg;

  localparam int ISSUE_WIDTH   = 4;
  localparam int PERF_CTR_BITS = 44;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [7:0]  rd;
    logic [15:0] tmask;
    logic [63:0] imm;
  } dispatch_t;

endpackage

// File: rtl/vx_dispatch_arbiter_if.sv
// Dispatch-side bundle between the issue slices, the arbiter and the EX unit.
interface vx_dispatch_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 128,
  parameter int SEL_W    = 2
);

  // A transfer happens in a cycle where valid and ready are both high;
  // valid never waits on ready, and an accepted payload is sampled that cycle.
  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0][DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]            req_ready;
  logic                           out_valid;
  logic [DATAW-1:0]               out_data;
  logic [SEL_W-1:0]               out_sel;
  logic                           out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module vx_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int SEL_W    = sel_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] requests,
  input  logic [SEL_W-1:0]    ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [SEL_W-1:0]    grant_index,
  output logic                grant_valid
);

  generate
    if (NUM_REQS == 1) begin : g_single
      assign grant       = requests;
      assign grant_index = '0;
      assign grant_valid = requests[0];
    end else begin : g_multi
      logic [SEL_W:0]   sum;
      logic [SEL_W-1:0] idx;

      // Scan from the farthest slot down so the nearest requester is kept.
      always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
          sum = {1'b0, ptr} + (SEL_W + 1)'(k);
          if (sum >= (SEL_W + 1)'(NUM_REQS)) begin
            sum = sum - (SEL_W + 1)'(NUM_REQS);
          end
          idx = sum[SEL_W-1:0];
          if (requests[idx]) begin
            grant       = '0;
            grant[idx]  = 1'b1;
            grant_index = idx;
            grant_valid = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/vx_dispatch_arbiter.sv
// Shares one EX dispatch port among the issue slices via round-robin grant
// and a 2-entry elastic output buffer; counts arbitration stall cycles.
module vx_dispatch_arbiter #(
  parameter int NUM_REQS      = VX_gpu_pkg::ISSUE_WIDTH,
  parameter int DATAW         = $bits(VX_gpu_pkg::dispatch_t),
  parameter int PERF_CTR_BITS = VX_gpu_pkg::PERF_CTR_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_dispatch_arbiter_if.slave     bus,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
);

  localparam int SEL_W = VX_gpu_pkg::sel_width(NUM_REQS);

  logic [SEL_W-1:0]    ptr;
  logic [1:0]          count;
  logic [DATAW-1:0]    data_q [2];
  logic [SEL_W-1:0]    sel_q  [2];
  logic                head;
  logic                tail;

  logic [NUM_REQS-1:0] grant;
  logic [SEL_W-1:0]    grant_index;
  logic                grant_valid;
  logic                full;
  logic                fire;
  logic                pop;
  logic [SEL_W-1:0]    ptr_next;
  logic [DATAW-1:0]    push_data;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .SEL_W    (SEL_W)
  ) u_rr (
    .requests    (bus.req_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  // Ready depends only on ptr/count and req_valid, never on out_ready.
  assign full          = (count == 2'd2);
  assign fire          = grant_valid && !full && !reset;
  assign pop           = (count != 2'd0) && bus.out_ready;
  assign bus.req_ready = (reset || full) ? '0 : grant;

  assign push_data = bus.req_data[grant_index];
  assign ptr_next  = (grant_index == SEL_W'(NUM_REQS - 1)) ? '0
                                                           : grant_index + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      count       <= 2'd0;
      head        <= 1'b0;
      tail        <= 1'b0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      sel_q[0]    <= '0;
      sel_q[1]    <= '0;
      perf_stalls <= '0;
    end else begin
      if (fire) begin
        ptr          <= ptr_next;
        data_q[tail] <= push_data;
        sel_q[tail]  <= grant_index;
        tail         <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      unique case ({fire, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (|bus.req_valid && !fire) begin
        perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
      end
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = data_q[head];
  assign bus.out_sel   = sel_q[head];

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.req_ready));
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count <= 2'd2);

endmodule

// File: tb/tb_vx_dispatch_arbiter.sv
// Bench for vx_dispatch_arbiter: directed scenarios plus a reference-model
// scoreboard that tracks grants, buffer order and the stall counter.
module tb_vx_dispatch_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int SW = 2;
  localparam int PW = 44;
  localparam int EW = SW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] perf_stalls;

  vx_dispatch_arbiter_if #(.NUM_REQS(N), .DATAW(DW), .SEL_W(SW)) bus ();

  vx_dispatch_arbiter #(
    .NUM_REQS      (N),
    .DATAW         (DW),
    .PERF_CTR_BITS (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] m_ptr;
  int            m_count;
  logic [PW-1:0] m_stalls;
  bit            mon_en = 1'b0;

  // Reference model, evaluated mid-cycle once inputs are stable.
  always @(negedge clk) begin : scoreboard
    logic [N-1:0]  e_ready;
    logic [EW-1:0] e;
    int            w;
    bit            f;
    e_ready = '0;
    w       = -1;
    f       = 1'b0;
    if (reset) begin
      checks++;
      if (bus.req_ready !== '0) begin
        errors++;
        $display("FAIL sb_reset_ready got %b want 0000", bus.req_ready);
      end
      exp_q.delete();
      m_ptr    = '0;
      m_count  = 0;
      m_stalls = '0;
      mon_en   = 1'b1;
    end else if (mon_en) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && bus.req_valid[(int'(m_ptr) + k) % N]) w = (int'(m_ptr) + k) % N;
      end
      f = (w >= 0) && (m_count < 2);
      if (f) e_ready[w] = 1'b1;
      checks++;
      if (bus.req_ready !== e_ready) begin
        errors++;
        $display("FAIL sb_req_ready got %b want %b", bus.req_ready, e_ready);
      end
      checks++;
      if (bus.out_valid !== (m_count != 0)) begin
        errors++;
        $display("FAIL sb_out_valid got %b want %b", bus.out_valid, m_count != 0);
      end
      checks++;
      if (perf_stalls !== m_stalls) begin
        errors++;
        $display("FAIL sb_perf_stalls got %0d want %0d", perf_stalls, m_stalls);
      end
      if (m_count != 0 && bus.out_valid === 1'b1) begin
        e = exp_q[0];
        checks++;
        if ({bus.out_sel, bus.out_data} !== e) begin
          errors++;
          $display("FAIL sb_head got sel %0d data %h want sel %0d data %h",
                   bus.out_sel, bus.out_data, e[EW-1:DW], e[DW-1:0]);
        end
      end
      if (m_count != 0 && bus.out_ready === 1'b1) begin
        void'(exp_q.pop_front());
        m_count--;
      end
      if (f) begin
        exp_q.push_back({SW'(w), bus.req_data[w]});
        m_ptr = SW'((w + 1) % N);
        m_count++;
      end
      if (|bus.req_valid && !f) m_stalls++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      bus.req_data[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = '1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_cycle_ready got %b want 0000", bus.req_ready);
    end
    next_cycle();
    reset         = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b want 0000", bus.req_ready);
    end
    checks++;
    if (perf_stalls !== '0 || bus.out_data !== '0 || bus.out_sel !== '0) begin
      errors++;
      $display("FAIL reset_regs got stalls %0d data %h sel %0d want 0",
               perf_stalls, bus.out_data, bus.out_sel);
    end
    repeat (10) next_cycle();
    @(negedge clk);
    checks++;
    if (perf_stalls !== '0) begin
      errors++;
      $display("FAIL idle_stalls got %0d want 0", perf_stalls);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  want;
    logic [SW-1:0] want_sel;
    apply_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = '1;
      rand_data();
      want     = 4'b0001 << (k % 4);
      want_sel = SW'((k + 3) % 4);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== want) begin
        errors++;
        $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, want);
      end
      if (k >= 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== want_sel) begin
          errors++;
          $display("FAIL rr_out_sel[%0d] got v%b sel %0d want v1 sel %0d",
                   k, bus.out_valid, bus.out_sel, want_sel);
        end
      end
      next_cycle();
    end
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (perf_stalls !== '0) begin
      errors++;
      $display("FAIL rr_stalls got %0d want 0", perf_stalls);
    end
    next_cycle();
  endtask

  task automatic test_fairness();
    int           seq[4];
    logic [N-1:0] want;
    seq = '{1, 3, 1, 3};
    apply_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 4'b1010;
      rand_data();
      want = 4'b0001 << seq[k];
      @(negedge clk);
      checks++;
      if (bus.req_ready !== want) begin
        errors++;
        $display("FAIL fair_ready[%0d] got %b want %b", k, bus.req_ready, want);
      end
      next_cycle();
    end
    bus.req_valid = 4'b1011;
    rand_data();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL fair_slice0 got %b want 0001", bus.req_ready);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL fair_after0 got %b want 0010", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = '0;
    repeat (3) next_cycle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] p0, p1, p2;
    apply_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    rand_data();
    @(negedge clk);
    p0 = bus.req_data[0];
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_fire0 got %b want 0001", bus.req_ready);
    end
    next_cycle();
    rand_data();
    @(negedge clk);
    p1 = bus.req_data[0];
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_fire1 got %b want 0001", bus.req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      rand_data();
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.out_data !== p0 || bus.out_sel !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got ready %b data %h sel %0d want 0000 %h 0",
                 k, bus.req_ready, bus.out_data, bus.out_sel, p0);
      end
    end
    next_cycle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (perf_stalls !== 44'd5) begin
      errors++;
      $display("FAIL bp_stalls got %0d want 5", perf_stalls);
    end
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.out_data !== p0) begin
      errors++;
      $display("FAIL bp_pop_first got ready %b data %h want 0000 %h",
               bus.req_ready, bus.out_data, p0);
    end
    next_cycle();
    rand_data();
    @(negedge clk);
    p2 = bus.req_data[0];
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.out_data !== p1) begin
      errors++;
      $display("FAIL bp_reassert got ready %b data %h want 0001 %h",
               bus.req_ready, bus.out_data, p1);
    end
    next_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== p2) begin
      errors++;
      $display("FAIL bp_last got v%b data %h want v1 %h", bus.out_valid, bus.out_data, p2);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained got %b want 0", bus.out_valid);
    end
    next_cycle();
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] pay[3];
    pay[0] = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A;
    pay[1] = 128'hBBBB_6666_7777_8888_9999_CCCC_DDDD_000B;
    pay[2] = 128'hCCCC_EEEE_FFFF_0123_4567_89AB_CDEF_000C;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      bus.req_data[2] = pay[k];
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL pp_ready[%0d] got %b want 0100", k, bus.req_ready);
      end
      if (k > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== pay[k-1] || bus.out_sel !== 2'd2) begin
          errors++;
          $display("FAIL pp_out[%0d] got v%b data %h sel %0d want v1 %h 2",
                   k, bus.out_valid, bus.out_data, bus.out_sel, pay[k-1]);
        end
      end
      next_cycle();
    end
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== pay[2]) begin
      errors++;
      $display("FAIL pp_out_c got v%b data %h want v1 %h", bus.out_valid, bus.out_data, pay[2]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_empty got %b want 0", bus.out_valid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    rand_data();
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full got ready %b v%b want 0000 v1", bus.req_ready, bus.out_valid);
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_dropped[%0d] got v%b want v0", k, bus.out_valid);
      end
      next_cycle();
    end
    bus.req_valid = '1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ptr got %b want 0001", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = '0;
    repeat (2) next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      bus.req_valid = N'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      next_cycle();
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got v%b want v0", bus.out_valid);
    end
    next_cycle();
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
